// File: rtl/mux_rr_select.sv
// mux_rr_select: round-robin 4-channel mux select sequencer with bounded bursts and a registered, channel-tagged Z sample
// Ports: clk/rst (sync, active-high), en (arbitration enable), req[3:0] (per-channel requests), z (mux output),
//        s1/s0 (registered mux selects), gnt[3:0] (one-hot grant), valid (grant active),
//        zq/zq_ch/zq_valid (Z sampled one cycle after each grant cycle, tagged with its channel)
module mux_rr_select #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       z,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       zq,
  output logic [1:0] zq_ch,
  output logic       zq_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state;
  logic [1:0] ptr, ch, base, pick;
  logic [3:0] burst, rot;
  logic [7:0] req2;
  logic       rel, go;
  assign ch   = {s1, s0};
  assign rel  = state == GRANT && (!req[ch] || burst == 4'(MAX_BURST) || !en);
  // a releasing channel hands priority to its neighbour in the same edge
  assign base = rel ? ch + 2'd1 : ptr;
  assign req2 = {req, req};
  assign rot  = req2[base +: 4];
  assign pick = base + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign go   = en && |req && (state == IDLE || rel);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      burst    <= '0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      gnt      <= '0;
      valid    <= 1'b0;
      zq       <= 1'b0;
      zq_ch    <= '0;
      zq_valid <= 1'b0;
    end else begin
      zq_valid <= valid;
      if (valid) begin
        zq    <= z;
        zq_ch <= ch;
      end
      if (rel) ptr <= base;
      if (go) begin
        state    <= GRANT;
        {s1, s0} <= pick;
        gnt      <= 4'b1 << pick;
        valid    <= 1'b1;
        burst    <= 4'd1;
      end else if (state == GRANT && !rel) begin
        burst <= burst + 4'd1;
      end else begin
        state <= IDLE;
        gnt   <= '0;
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_select.sv
// tb_mux_rr_select: scoreboard bench comparing two mux_rr_select instances (bursts 4 and 2) against a behavioural model
module tb_mux_rr_select;
  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] sel;
    logic       zq;
    logic [1:0] zq_ch;
    logic       zqv;
  } obs_t;
  logic       clk = 0;
  logic       rst = 1, en = 0;
  logic [3:0] req = 0, d = 0;
  logic       s1_a, s0_a, v_a, zq_a, zqv_a, s1_b, s0_b, v_b, zq_b, zqv_b;
  logic [3:0] g_a, g_b;
  logic [1:0] zc_a, zc_b;
  logic       z_a, z_b;
  obs_t       q0[$], q1[$];
  int         checks = 0, fails = 0;
  int         mb[2] = '{4, 2};
  int         ptr[2], cur[2], burst[2];
  bit         act[2];
  obs_t       mo[2];
  assign z_a = d[{s1_a, s0_a}];
  assign z_b = d[{s1_b, s0_b}];
  mux_rr_select #(.MAX_BURST(4)) u_a (.clk(clk), .rst(rst), .en(en), .req(req), .z(z_a),
    .s1(s1_a), .s0(s0_a), .gnt(g_a), .valid(v_a), .zq(zq_a), .zq_ch(zc_a), .zq_valid(zqv_a));
  mux_rr_select #(.MAX_BURST(2)) u_b (.clk(clk), .rst(rst), .en(en), .req(req), .z(z_b),
    .s1(s1_b), .s0(s0_b), .gnt(g_b), .valid(v_b), .zq(zq_b), .zq_ch(zc_b), .zq_valid(zqv_b));
  always #5 clk = ~clk;
  task automatic model_step(input int i);
    obs_t n;
    bit   want;
    n = mo[i];
    if (rst) begin
      n = '0;
      ptr[i] = 0; cur[i] = 0; burst[i] = 0; act[i] = 0;
    end else begin
      n.zqv = mo[i].valid;
      if (mo[i].valid) begin
        n.zq    = d[mo[i].sel];
        n.zq_ch = mo[i].sel;
      end
      want = 1;
      if (act[i]) begin
        if (!req[cur[i]] || burst[i] == mb[i] || !en) ptr[i] = (cur[i] + 1) % 4;
        else begin
          burst[i]++;
          want = 0;
        end
      end
      if (want) begin
        act[i] = 0;
        if (en && req != 0)
          for (int k = 0; k < 4; k++)
            if (!act[i] && req[(ptr[i] + k) % 4]) begin
              act[i] = 1; cur[i] = (ptr[i] + k) % 4; burst[i] = 1;
            end
      end
      n.valid = act[i];
      n.gnt   = act[i] ? 4'(1 << cur[i]) : 4'd0;
      if (act[i]) n.sel = 2'(cur[i]);
    end
    mo[i] = n;
  endtask
  task automatic cyc(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] dd, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = r; en = e; req = rq; d = dd;
      model_step(0);
      model_step(1);
      q0.push_back(mo[0]);
      q1.push_back(mo[1]);
    end
  endtask
  always begin
    obs_t e, a;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {g_a, v_a, s1_a, s0_a, zq_a, zc_a, zqv_a};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL burst4 t=%0t got %b want %b (gnt,valid,sel,zq,zq_ch,zq_valid)", $time, a, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {g_b, v_b, s1_b, s0_b, zq_b, zc_b, zqv_b};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL burst2 t=%0t got %b want %b (gnt,valid,sel,zq,zq_ch,zq_valid)", $time, a, e);
      end
    end
  end
  initial begin
    mo[0] = '0; mo[1] = '0;
    cyc(1, 1, 4'b1111, 4'b0000, 2);
    cyc(0, 1, 4'b1111, 4'b0000, 3);
    cyc(1, 1, 4'b0000, 4'b0100, 1);
    cyc(0, 1, 4'b0100, 4'b0100, 14);
    cyc(1, 1, 4'b0000, 4'b0101, 1);
    cyc(0, 1, 4'b1111, 4'b0101, 20);
    cyc(1, 1, 4'b0000, 4'b0000, 1);
    cyc(0, 1, 4'b0011, 4'b0011, 2);
    cyc(0, 1, 4'b0010, 4'b0011, 1);
    cyc(0, 1, 4'b0011, 4'b0011, 6);
    cyc(1, 1, 4'b0000, 4'b1000, 1);
    cyc(0, 1, 4'b1000, 4'b1000, 3);
    cyc(0, 0, 4'b1000, 4'b1000, 3);
    cyc(0, 1, 4'b1000, 4'b1000, 2);
    cyc(1, 1, 4'b1000, 4'b1000, 1);
    cyc(0, 1, 4'b1000, 4'b1000, 3);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, 4'($urandom), 4'($urandom), 1);
    repeat (2) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d pending want 0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mux_rr_select.md
# mux_rr_select

Round-robin select sequencer that drives the select inputs (S1, S0) of the 4-to-1 multiplexer `mux4to1` and registers the multiplexer output Z. Four requesters compete for the mux. The block grants one channel at a time with fair rotation and a bounded burst length, then presents a registered, channel-tagged sample of Z to downstream logic.

## Interface
- MAX_BURST, default 4: maximum consecutive grant cycles per channel; legal range 1..15.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  arbitration enable.
- REQ  in  4  per-channel request; bit i requests mux input Di.
- Z  in  1  mux output, combinational from the current S1/S0.
- S1  out  1  mux select MSB, registered.
- S0  out  1  mux select LSB, registered.
- GNT  out  4  one-hot grant, registered; all zeros when idle.
- VALID  out  1  high while a grant is active.
- ZQ  out  1  registered sample of Z.
- ZQ_CH  out  2  channel index {S1,S0} at which ZQ was sampled.
- ZQ_VALID  out  1  ZQ/ZQ_CH hold a new sample this cycle.

## Operation
- Reset values: S1=0, S0=0, GNT=0000, VALID=0, ZQ=0, ZQ_CH=00, ZQ_VALID=0. Internally, priority pointer PTR=0, burst counter=0, state IDLE.
- States: IDLE and GRANT.
- Channel pick: the first i with REQ[i]=1, searching PTR, PTR+1, … modulo 4.
- IDLE:
  - If EN=1 and REQ≠0, pick channel c. On the next edge: state GRANT, {S1,S0}=c, GNT=1<<c, VALID=1, burst=1.
  - Otherwise remain IDLE. GNT=0 and VALID=0. S1/S0 hold their last value, so there are no spurious select changes.
- GRANT on channel c: release when any of REQ[c]=0, burst==MAX_BURST, or EN=0.
  - No release: stay on c and increment burst.
  - On release: PTR←(c+1) mod 4. If EN=1 and REQ≠0, pick from the new PTR and grant immediately with burst=1 (no idle bubble). Otherwise go to IDLE.
  - Burst expiry with c as the only requester: c is re-granted with burst=1.
- Burst counter is 4 bits and never exceeds MAX_BURST.
- PTR wraps 3→0.
- Sampling: every cycle with VALID=1, the next edge loads ZQ←Z, ZQ_CH←{S1,S0}, ZQ_VALID←1. Otherwise ZQ_VALID←0, and ZQ/ZQ_CH hold.
- RST=1 at any edge, including mid-burst, forces all reset values at that edge. RST has priority over EN/REQ.

## Timing
- REQ and EN are sampled at the rising edge. The grant is visible on the cycle after the sampling edge: 1-cycle request-to-grant latency.
- S1/S0 change only at edges. Z is assumed settled within the same cycle.
- ZQ_VALID follows VALID by exactly 1 cycle. The sample count equals the grant-cycle count.
- Grant hand-off between channels takes 0 idle cycles. GNT is never multi-hot, and GNT≠0 exactly when VALID=1.
- Simultaneous release and new requests: the new grant uses the updated PTR in the same edge.
- EN falling mid-grant ends the grant at the next edge. The last sample still emerges 1 cycle later.

## Test plan
- Reset: hold RST=1 for 2 cycles with REQ=1111 and EN=1. All outputs must be at reset values. After release, the first grant appears 1 cycle later on channel 0: {S1,S0}=00, GNT=0001.
- Single requester, MAX_BURST=4: REQ=0100 held, D2=1, others 0.
  - Expect GNT=0100 and {S1,S0}=10 continuously (re-grant after every 4 cycles).
  - ZQ=1 and ZQ_CH=10, with ZQ_VALID=1 from cycle 2 onward.
- Rotation: REQ=1111 held, MAX_BURST=2. Grant order is 0,0,1,1,2,2,3,3,0… with no gap cycles. Drive D0..D3=1,0,1,0; ZQ must follow 1,1,0,0,1,1,0,0 one cycle delayed.
- Early release: REQ=0011, then drop REQ[0] after 1 grant cycle. The grant must move to channel 1 at the next edge. PTR becomes 1, so with REQ=0011 restored, channel 1 keeps priority over 0.
- EN drop and mid-burst reset:
  - Deassert EN during a grant on channel 3. Expect VALID=0 and GNT=0000 at the next edge, S1/S0 holding 11, and one final ZQ_VALID pulse.
  - Assert RST mid-burst. All outputs must reset at that edge.
